// File: rtl/mips_pkg.sv
// Shared encodings for the writeback stage: source select, load size,
// controller state, and the context captured for an outstanding load.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    MS_BYTE = 2'd0,
    MS_HALF = 2'd1,
    MS_WORD = 2'd2,
    MS_RSVD = 2'd3
  } mem_size_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  // Everything needed to finish a load once the memory answers.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
    mem_size_e        size;
    logic             sgn;
    logic [1:0]       off;
  } load_ctx_t;

  // Halfwords need an even offset; words (and the reserved size, handled
  // like a word) need offset zero. Bytes are always aligned.
  function automatic logic is_misaligned(mem_size_e size, logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      MS_BYTE: bad = 1'b0;
      MS_HALF: bad = off[0];
      default: bad = (off != 2'd0);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/reg_writeback_load_extend.sv
// Combinational byte/half/word lane selection and sign/zero extension of an
// aligned memory word.
module load_extend
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  mem_size_e         size,
  input  logic              sgn,
  input  logic [1:0]        off,
  output logic [DATA_W-1:0] data
);

  function automatic logic [DATA_W-1:0] extend_byte(logic signed [7:0] b, logic s);
    return s ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] extend_half(logic signed [15:0] h, logic s);
    return s ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
  endfunction

  logic [DATA_W-1:0] shifted;

  // Rotate the addressed lane down to bit 0, then extend by size.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    data    = rdata;
    case (size)
      MS_BYTE: data = extend_byte(shifted[7:0], sgn);
      MS_HALF: data = extend_half(shifted[15:0], sgn);
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: selects ALU / link / load data, waits for load responses,
// and drives a registered register-file write port plus status counters.
module reg_writeback
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_pc_plus8,
  input  logic [1:0]        in_mem_size,
  input  logic              in_mem_signed,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              w_rb,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] din,
  output logic              align_err,
  output logic              spurious_rsp,
  output logic [31:0]       retired
);

  wb_state_e         state_q, state_d;
  load_ctx_t         ctx_p0;
  wb_sel_e           sel_p0;
  mem_size_e         size_p0;
  logic              accept_p0;
  logic              mem_req_p0;
  logic              bad_p0;
  logic              ld_go_p0;
  logic              direct_p0;
  logic              ld_done_p0;
  logic              vld_p0;
  logic              we_p0;
  logic [4:0]        rd_p0;
  logic [DATA_W-1:0] val_p0;
  logic [DATA_W-1:0] direct_val_p0;
  logic [DATA_W-1:0] load_val_p0;

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .rdata (mem_rdata),
    .size  (ctx_p0.size),
    .sgn   (ctx_p0.sgn),
    .off   (ctx_p0.off),
    .data  (load_val_p0)
  );

  // Stage p0: decode the incoming request or the load response into one commit.
  always_comb begin
    sel_p0        = wb_sel_e'(in_wb_sel);
    size_p0       = mem_size_e'(in_mem_size);
    accept_p0     = in_valid && in_ready;
    mem_req_p0    = accept_p0 && (sel_p0 == WB_MEM);
    bad_p0        = mem_req_p0 && is_misaligned(size_p0, in_alu_result[1:0]);
    ld_go_p0      = mem_req_p0 && !bad_p0;
    direct_p0     = accept_p0 && (sel_p0 != WB_MEM);
    ld_done_p0    = (state_q == ST_WAIT_MEM) && mem_rvalid;
    direct_val_p0 = (sel_p0 == WB_LINK) ? in_pc_plus8 : in_alu_result;
    vld_p0        = direct_p0 || ld_done_p0;
    we_p0         = ld_done_p0 ? ctx_p0.we : in_reg_write;
    rd_p0         = ld_done_p0 ? ctx_p0.rd : in_rd;
    val_p0        = ld_done_p0 ? load_val_p0 : direct_val_p0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: enter WAIT_MEM on an aligned load, leave on its response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (ld_go_p0)   state_d = ST_WAIT_MEM;
      ST_WAIT_MEM: if (mem_rvalid) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state_q == ST_IDLE);
  end

  // Capture the load context on accept; only read while waiting.
  always_ff @(posedge clk) begin
    if (ld_go_p0) begin
      ctx_p0.rd   <= in_rd;
      ctx_p0.we   <= in_reg_write;
      ctx_p0.size <= size_p0;
      ctx_p0.sgn  <= in_mem_signed;
      ctx_p0.off  <= in_alu_result[1:0];
    end
  end

  // Stage p1: registered write port; rd/din only move on a real write.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_rb <= 1'b0;
      rd   <= '0;
      din  <= '0;
    end else begin
      w_rb <= vld_p0 && we_p0 && (rd_p0 != 5'd0);
      if (vld_p0 && we_p0 && (rd_p0 != 5'd0)) begin
        rd  <= rd_p0;
        din <= val_p0;
      end
    end
  end

  // Status: alignment pulse, sticky stray-response flag, retirement count.
  always_ff @(posedge clk) begin
    if (rst) begin
      align_err    <= 1'b0;
      spurious_rsp <= 1'b0;
      retired      <= '0;
    end else begin
      align_err <= bad_p0;
      if ((state_q == ST_IDLE) && mem_rvalid) spurious_rsp <= 1'b1;
      if (vld_p0 || bad_p0) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a transaction-level reference model.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus8;
  logic [1:0]  in_mem_size;
  logic        in_mem_signed;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        w_rb;
  logic [4:0]  rd;
  logic [31:0] din;
  logic        align_err;
  logic        spurious_rsp;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  reg_writeback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc_plus8(in_pc_plus8),
    .in_mem_size(in_mem_size), .in_mem_signed(in_mem_signed),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .w_rb(w_rb), .rd(rd), .din(din), .align_err(align_err),
    .spurious_rsp(spurious_rsp), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load extraction from the byte-lane rules.
  function automatic logic [31:0] model_load(logic [31:0] data, int sz, bit sgn, int off);
    logic [31:0] sh;
    logic [31:0] v;
    sh = data >> (8 * off);
    if (sz == 0) begin
      v = sh & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = sh & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = data;
    end
    return v;
  endfunction

  // Model state: a pending load record plus expected outputs.
  bit          m_pend = 0;
  int          m_prd, m_psz, m_poff;
  bit          m_pwe, m_psgn;
  bit          m_w = 0, m_al = 0, m_spur = 0;
  logic [31:0] m_rd = 0, m_din = 0, m_ret = 0;

  task automatic model_write(input bit we, input int r, input logic [31:0] v);
    m_ret = m_ret + 1;
    if (we && r != 0) begin
      m_w = 1; m_rd = r; m_din = v;
    end
  endtask

  // Advance the model at each edge from the inputs, then compare after it.
  always @(posedge clk) begin
    int off, sz;
    if (rst) begin
      m_pend = 0; m_w = 0; m_al = 0; m_spur = 0; m_rd = 0; m_din = 0; m_ret = 0;
    end else begin
      m_w = 0; m_al = 0;
      if (!m_pend) begin
        if (mem_rvalid) m_spur = 1;
        if (in_valid) begin
          if (in_wb_sel == 2'd1) begin
            off = int'(in_alu_result % 4);
            sz  = int'(in_mem_size);
            if ((sz == 1 && off % 2 == 1) || (sz >= 2 && off != 0)) begin
              m_al = 1; m_ret = m_ret + 1;
            end else begin
              m_pend = 1; m_prd = int'(in_rd); m_pwe = in_reg_write;
              m_psz = sz; m_psgn = in_mem_signed; m_poff = off;
            end
          end else begin
            model_write(in_reg_write, int'(in_rd),
                        (in_wb_sel == 2'd2) ? in_pc_plus8 : in_alu_result);
          end
        end
      end else if (mem_rvalid) begin
        m_pend = 0;
        model_write(m_pwe, m_prd, model_load(mem_rdata, m_psz, m_psgn, m_poff));
      end
    end
    #1;
    chk("m_w_rb", {31'd0, w_rb}, {31'd0, m_w});
    chk("m_rd", {27'd0, rd}, m_rd);
    chk("m_din", din, m_din);
    chk("m_align_err", {31'd0, align_err}, {31'd0, m_al});
    chk("m_spurious", {31'd0, spurious_rsp}, {31'd0, m_spur});
    chk("m_retired", retired, m_ret);
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, !m_pend});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic [1:0] sel, input logic [4:0] r, input logic we,
                     input logic [31:0] alu, input logic [31:0] pc8,
                     input logic [1:0] sz, input logic sgn);
    in_valid = 1'b1; in_wb_sel = sel; in_rd = r; in_reg_write = we;
    in_alu_result = alu; in_pc_plus8 = pc8; in_mem_size = sz; in_mem_signed = sgn;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; mem_rvalid = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_rd = 0; in_reg_write = 0; in_wb_sel = 0;
    in_alu_result = 0; in_pc_plus8 = 0; in_mem_size = 0; in_mem_signed = 0;
    mem_rvalid = 0; mem_rdata = 0;
    do_reset();
    chk("rst_w_rb", {31'd0, w_rb}, 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_spur", {31'd0, spurious_rsp}, 32'd0);

    // ALU write to r2
    req(2'd0, 5'd2, 1'b1, 32'h45, 32'h0, 2'd0, 1'b0);
    tick(); in_valid = 0;
    chk("alu_w_rb", {31'd0, w_rb}, 32'd1);
    chk("alu_rd", {27'd0, rd}, 32'd2);
    chk("alu_din", din, 32'h45);
    chk("alu_retired", retired, 32'd1);
    tick();
    chk("alu_w_rb_once", {31'd0, w_rb}, 32'd0);

    // Signed byte load, offset 3, response after waiting
    req(2'd1, 5'd5, 1'b1, 32'h0000_1003, 32'h0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); in_valid = 0;
      chk("sb_wait_ready", {31'd0, in_ready}, 32'd0);
      chk("sb_wait_w_rb", {31'd0, w_rb}, 32'd0);
    end
    mem_rvalid = 1; mem_rdata = 32'h8012_3456;
    tick(); mem_rvalid = 0;
    chk("sb_w_rb", {31'd0, w_rb}, 32'd1);
    chk("sb_rd", {27'd0, rd}, 32'd5);
    chk("sb_din", din, 32'hFFFF_FF80);
    chk("sb_ready", {31'd0, in_ready}, 32'd1);

    // Unsigned half, offset 2
    req(2'd1, 5'd6, 1'b1, 32'h0000_2002, 32'h0, 2'd1, 1'b0);
    tick(); in_valid = 0; mem_rvalid = 1; mem_rdata = 32'hBEEF_1234;
    tick(); mem_rvalid = 0;
    chk("uh_din", din, 32'h0000_BEEF);

    // Signed half offset 0, unsigned byte offset 1
    req(2'd1, 5'd8, 1'b1, 32'h0000_3000, 32'h0, 2'd1, 1'b1);
    tick(); in_valid = 0; mem_rvalid = 1; mem_rdata = 32'h1234_8001;
    tick(); mem_rvalid = 0;
    chk("sh_din", din, 32'hFFFF_8001);
    req(2'd1, 5'd9, 1'b1, 32'h0000_3001, 32'h0, 2'd0, 1'b0);
    tick(); in_valid = 0; mem_rvalid = 1; mem_rdata = 32'h1234_ABCD;
    tick(); mem_rvalid = 0;
    chk("ub_din", din, 32'h0000_00AB);

    // LINK to r31 then ALU to r0 back-to-back
    do_reset();
    req(2'd2, 5'd31, 1'b1, 32'h0, 32'h0040_0010, 2'd0, 1'b0);
    tick();
    chk("link_w_rb", {31'd0, w_rb}, 32'd1);
    chk("link_rd", {27'd0, rd}, 32'd31);
    chk("link_din", din, 32'h0040_0010);
    req(2'd0, 5'd0, 1'b1, 32'h1234, 32'h0, 2'd0, 1'b0);
    tick(); in_valid = 0;
    chk("r0_w_rb", {31'd0, w_rb}, 32'd0);
    chk("r0_din_held", din, 32'h0040_0010);
    chk("r0_retired", retired, 32'd2);

    // Misaligned word and half loads
    req(2'd1, 5'd4, 1'b1, 32'h0000_0201, 32'h0, 2'd2, 1'b0);
    tick(); in_valid = 0;
    chk("mw_align", {31'd0, align_err}, 32'd1);
    chk("mw_w_rb", {31'd0, w_rb}, 32'd0);
    chk("mw_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("mw_align_pulse", {31'd0, align_err}, 32'd0);
    req(2'd1, 5'd4, 1'b1, 32'h0000_0203, 32'h0, 2'd1, 1'b1);
    tick(); in_valid = 0;
    chk("mh_align", {31'd0, align_err}, 32'd1);

    // Reserved select as ALU, no-write request, stray response with accept
    req(2'd3, 5'd10, 1'b1, 32'h33, 32'h77, 2'd0, 1'b0);
    tick();
    chk("rsv_din", din, 32'h33);
    req(2'd0, 5'd11, 1'b0, 32'h55, 32'h0, 2'd0, 1'b0);
    tick();
    req(2'd0, 5'd12, 1'b1, 32'hA5A5, 32'h0, 2'd0, 1'b0);
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    tick(); in_valid = 0; mem_rvalid = 0;
    chk("stray_din", din, 32'hA5A5);
    chk("stray_spur", {31'd0, spurious_rsp}, 32'd1);

    // Reset beats an accept in the same cycle
    do_reset();
    req(2'd0, 5'd3, 1'b1, 32'h99, 32'h0, 2'd0, 1'b0);
    rst = 1;
    tick(); rst = 0; in_valid = 0;
    chk("rstpri_w_rb", {31'd0, w_rb}, 32'd0);
    chk("rstpri_retired", retired, 32'd0);

    // Reset abandons a pending load; late response is spurious
    req(2'd1, 5'd7, 1'b1, 32'h0000_0100, 32'h0, 2'd2, 1'b0);
    tick(); in_valid = 0;
    chk("ab_wait_ready", {31'd0, in_ready}, 32'd0);
    rst = 1;
    tick(); rst = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    tick(); mem_rvalid = 0;
    chk("ab_w_rb", {31'd0, w_rb}, 32'd0);
    chk("ab_spur", {31'd0, spurious_rsp}, 32'd1);
    chk("ab_retired", retired, 32'd0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  writeback request present from MEM stage.
REQ-005 in_ready  output  1  block can accept a request; combinational, equals (state==IDLE).
REQ-006 in_rd  input  5  destination register index.
REQ-007 in_reg_write  input  1  request writes a register.
REQ-008 in_wb_sel  input  2  source: ALU=0, MEM=1, LINK=2; 3 reserved, treated as ALU.
REQ-009 in_alu_result  input  32  ALU result; bits[1:0] give the byte offset for MEM.
REQ-010 in_pc_plus8  input  32  link value for LINK.
REQ-011 in_mem_size, in_mem_signed  input  2, 1  load size (BYTE=0, HALF=1, WORD=2) and sign-extend flag.
REQ-012 mem_rvalid, mem_rdata  input  1, 32  data-memory load response (aligned word).
REQ-013 w_rb, rd, din  output  1, 5, 32  register-file write port, registered; the file samples it on negedge clk.
REQ-014 align_err  output  1  one-cycle pulse on a misaligned load.
REQ-015 spurious_rsp  output  1  sticky flag: mem_rvalid seen while IDLE.
REQ-016 retired  output  32  count of completed requests.

Function
REQ-017 States SHALL be IDLE and WAIT_MEM.
REQ-018 Accept = in_valid && in_ready.
REQ-019 An accepted ALU/LINK request SHALL drive w_rb=in_reg_write&&(in_rd!=0), rd=in_rd, din=selected value in the next cycle; state stays IDLE, so back-to-back accepts give back-to-back writes.
REQ-020 An accepted MEM request SHALL latch rd, size, signed and offset, then go to WAIT_MEM; w_rb=0 the next cycle.
REQ-021 In WAIT_MEM, on mem_rvalid=1 the block SHALL write the extracted value the next cycle and return to IDLE; any other cycle holds state with w_rb=0.
REQ-022 Extraction: BYTE selects byte[offset]; HALF selects bits[15:0] when offset=0 and bits[31:16] when offset=2; WORD passes through. The signed flag sign-extends, otherwise zero-extends.
REQ-023 A misaligned load (HALF with offset[0]=1, WORD with offset!=0) SHALL pulse align_err in the cycle after accept, stay IDLE, leave w_rb=0, and not wait for a response.
REQ-024 Writes to rd=0 SHALL be suppressed (w_rb=0) but still count as retired.
REQ-025 w_rb SHALL be 1 for exactly one cycle per write and 0 otherwise; rd/din hold their last value when w_rb=0.
REQ-026 retired SHALL increment on each write cycle, suppressed write, or align_err, and wrap from 0xFFFFFFFF to 0.
REQ-027 mem_rvalid in IDLE SHALL set spurious_rsp and be otherwise ignored; an accept in the same cycle proceeds normally.

Reset
REQ-028 On rst: state=IDLE, w_rb=0, rd=0, din=0, align_err=0, spurious_rsp=0, retired=0.
REQ-029 Reset in WAIT_MEM SHALL abandon the pending load with no write; a later mem_rvalid sets spurious_rsp.
REQ-030 rst SHALL take priority over accept and mem_rvalid in the same cycle.

Structure
REQ-031 The shared package mips_pkg SHALL hold the wb_sel and mem_size encodings and the state enum.
REQ-032 Byte/half extraction and extension SHALL be a combinational sub-module load_extend.

Verification
REQ-033 ALU write: accept rd=2, alu=0x45 -> next cycle w_rb=1, rd=2, din=0x45, retired=1.
REQ-034 Signed byte load: offset=3, mem_rdata=0x80123456 after 3 wait cycles -> in_ready=0 while waiting; then w_rb=1, din=0xFFFFFF80.
REQ-035 Unsigned half: offset=2, mem_rdata=0xBEEF1234 -> din=0x0000BEEF.
REQ-036 LINK to rd=31, pc_plus8=0x00400010, followed by ALU to rd=0 back-to-back -> one write of 0x00400010 to r31, second request suppressed, retired=2.
REQ-037 WORD load with offset=1 -> align_err pulse, no write, in_ready stays 1.
REQ-038 rst asserted in WAIT_MEM, then mem_rvalid=1 -> no write, spurious_rsp=1, retired=0.
